// File: rtl/candy_sram_ctrl.sv
// -----------------------------------------------------------------------------
// candy_sram_ctrl
//   Arbitrating controller for a single-port asynchronous SRAM shared by an
//   instruction-fetch (IF) read port and a MEM-stage read/write port.
//   Each transfer is IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE (1 cycle).
//   All outputs are registered.
//
// Parameters
//   WAIT_CYCLES      SRAM access cycles per transfer (1..15)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_sram_addr             IF read address
//   if_read_enable           IF read request (level, held until if_data_ready)
//   if_data_ready, if_data   IF completion pulse and read data
//   mem_sram_addr            MEM address
//   mem_read_enable          MEM read request (level)
//   mem_write_enable         MEM write request (level, wins over read)
//   mem_wdata                MEM write data
//   mem_data_ready, mem_data MEM completion pulse and read data
//   sram_addr                external SRAM address
//   sram_dq_o, sram_dq_i     external data bus, write / read halves
//   sram_dq_oe               high while the controller drives the data bus
//   sram_ce_n/oe_n/we_n      active-low SRAM strobes
//   busy                     high whenever the controller is not idle
// -----------------------------------------------------------------------------
module candy_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] if_sram_addr,
    input  logic        if_read_enable,
    output logic        if_data_ready,
    output logic [23:0] if_data,
    input  logic [16:0] mem_sram_addr,
    input  logic        mem_read_enable,
    input  logic        mem_write_enable,
    input  logic [23:0] mem_wdata,
    output logic        mem_data_ready,
    output logic [23:0] mem_data,
    output logic [16:0] sram_addr,
    output logic [23:0] sram_dq_o,
    input  logic [23:0] sram_dq_i,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_e;

    localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;        // latched operation: 1 = write
    logic        mem_q, mem_d;      // latched requester: 1 = MEM, 0 = IF
    logic [16:0] addr_q, addr_d;
    logic [23:0] dq_o_q, dq_o_d;
    logic        dq_oe_q, dq_oe_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic [23:0] if_data_q, if_data_d;
    logic [23:0] mem_data_q, mem_data_d;
    logic        if_rdy_q, if_rdy_d;
    logic        mem_rdy_q, mem_rdy_d;
    logic        busy_q, busy_d;

    // Strobes, address and write data are computed one cycle ahead so that
    // they change on the same edge as the state they belong to.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        mem_d      = mem_q;
        addr_d     = addr_q;
        dq_o_d     = dq_o_q;
        dq_oe_d    = dq_oe_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        if_data_d  = if_data_q;
        mem_data_d = mem_data_q;
        if_rdy_d   = 1'b0;
        mem_rdy_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_write_enable || mem_read_enable || if_read_enable) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                    if (mem_write_enable) begin
                        wr_d   = 1'b1;
                        mem_d  = 1'b1;
                        addr_d = mem_sram_addr;
                        dq_o_d = mem_wdata;
                    end else if (mem_read_enable) begin
                        wr_d   = 1'b0;
                        mem_d  = 1'b1;
                        addr_d = mem_sram_addr;
                    end else begin
                        wr_d   = 1'b0;
                        mem_d  = 1'b0;
                        addr_d = if_sram_addr;
                    end
                    ce_n_d  = 1'b0;
                    oe_n_d  = wr_d;
                    we_n_d  = ~wr_d;
                    dq_oe_d = wr_d;
                end
            end

            S_ACCESS: begin
                if (cnt_q == LastCnt) begin
                    state_d = S_DONE;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    // Write keeps driving the bus through DONE for hold time.
                    if (!wr_q) begin
                        if (mem_q) begin
                            mem_data_d = sram_dq_i;
                        end else begin
                            if_data_d = sram_dq_i;
                        end
                    end
                    if (mem_q) begin
                        mem_rdy_d = 1'b1;
                    end else begin
                        if_rdy_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                dq_oe_d = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            mem_q      <= 1'b0;
            addr_q     <= '0;
            dq_o_q     <= '0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            if_data_q  <= '0;
            mem_data_q <= '0;
            if_rdy_q   <= 1'b0;
            mem_rdy_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            mem_q      <= mem_d;
            addr_q     <= addr_d;
            dq_o_q     <= dq_o_d;
            dq_oe_q    <= dq_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            if_data_q  <= if_data_d;
            mem_data_q <= mem_data_d;
            if_rdy_q   <= if_rdy_d;
            mem_rdy_q  <= mem_rdy_d;
            busy_q     <= busy_d;
        end
    end

    assign sram_addr      = addr_q;
    assign sram_dq_o      = dq_o_q;
    assign sram_dq_oe     = dq_oe_q;
    assign sram_ce_n      = ce_n_q;
    assign sram_oe_n      = oe_n_q;
    assign sram_we_n      = we_n_q;
    assign if_data        = if_data_q;
    assign mem_data       = mem_data_q;
    assign if_data_ready  = if_rdy_q;
    assign mem_data_ready = mem_rdy_q;
    assign busy           = busy_q;

endmodule

// File: doc/candy_sram_ctrl.md
CANDY_SRAM_CTRL -- requirements
Module: candy_sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of SRAM access cycles per transfer; legal range 1..15.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset (`RstEnable`).
REQ-004 if_sram_addr  in  `SRAMAddrWidth` (17)  fetch read address.
REQ-005 if_read_enable  in  1  fetch read request; level, held until if_data_ready.
REQ-006 if_data_ready  out  1  one-cycle pulse: if_data valid.
REQ-007 if_data  out  `SRAMDataWidth` (24)  fetch read data.
REQ-008 mem_sram_addr  in  17  MEM-stage address.
REQ-009 mem_read_enable / mem_write_enable  in  1 each  MEM-stage read/write request; level, held until mem_data_ready.
REQ-010 mem_wdata  in  24  MEM-stage write data.
REQ-011 mem_data_ready  out  1  one-cycle pulse: MEM transfer complete; mem_data valid for reads.
REQ-012 mem_data  out  24  MEM-stage read data.
REQ-013 sram_addr  out  17  external SRAM address.
REQ-014 sram_dq_o / sram_dq_i  out / in  24  external data bus, write / read halves.
REQ-015 sram_dq_oe  out  1  high: controller drives data bus.
REQ-016 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 FSM states IDLE, ACCESS, DONE; all outputs registered.
REQ-019 IDLE grant priority: mem_write_enable > mem_read_enable > if_read_enable; no request -> stay IDLE.
REQ-020 At grant edge: latch address, wdata, operation (read/write) and requester (IF/MEM); go to ACCESS, wait counter = 0.
REQ-021 Latched values are used for the whole transfer; input changes after the grant edge are ignored.
REQ-022 ACCESS lasts exactly WAIT_CYCLES cycles: sram_ce_n=0, sram_addr=latched address; read -> sram_oe_n=0; write -> sram_we_n=0, sram_dq_oe=1, sram_dq_o=latched wdata.
REQ-023 Final ACCESS edge: read -> sram_dq_i sampled into if_data or mem_data of the granted requester; go to DONE.
REQ-024 DONE lasts one cycle: granted requester's data_ready=1; strobes high (ce_n, oe_n, we_n = 1); write keeps sram_dq_oe=1 and sram_dq_o stable (hold); then IDLE.
REQ-025 Latency: grant at edge k -> data_ready high between edges k+WAIT_CYCLES and k+WAIT_CYCLES+1; next grant no earlier than edge k+WAIT_CYCLES+2.
REQ-026 Ungranted requester's data_ready stays 0 and its data register holds its previous value.
REQ-027 Writes never modify if_data or mem_data; mem_data_ready still pulses on write completion.
REQ-028 mem_read_enable and mem_write_enable both high: treated as write.
REQ-029 Losing requester is not queued; it is re-evaluated in the next IDLE cycle as long as its request remains high.
REQ-030 Never more than one data_ready high in a cycle; sram_oe_n and sram_we_n never both 0.

Reset
REQ-031 rst=1 at any edge, including mid-ACCESS or DONE: state IDLE, counter 0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0, ce_n/oe_n/we_n=1, if_data=mem_data=0, both data_ready=0, busy=0; any in-flight transfer is abandoned with no data_ready.
REQ-032 First grant is possible at the first edge with rst=0.

Verification
REQ-033 WAIT_CYCLES=2, IF read addr 17'h012, sram_dq_i=24'h027890 -> sram_addr=0x012, oe_n low 2 cycles, single if_data_ready pulse 2 edges after grant, if_data=24'h027890.
REQ-034 IF read 0x012 and MEM read 0x100 asserted together -> MEM served first (mem_data_ready), then IF granted in a later IDLE cycle; no overlapping ready pulses.
REQ-035 MEM write addr 0x0A5, wdata 24'hABCDEF -> we_n low 2 cycles, dq_oe high 3 cycles, dq_o=24'hABCDEF, mem_data_ready pulse, if_data/mem_data unchanged.
REQ-036 rst asserted in the first ACCESS cycle -> next cycle all strobes high, busy=0, no ready pulse; request still high after reset release -> granted at first edge.
REQ-037 if_sram_addr changed 0x012 -> 0x034 mid-ACCESS -> sram_addr stays 0x012 through DONE.
REQ-038 WAIT_CYCLES=1, back-to-back IF reads 0x001, 0x002 -> each ready pulse 1 edge after its grant; grants 3 cycles apart.
